// File: rtl/decrypt_3blocks_128_if.sv
// Request/response bundle of the Ascon-128 three-block decryptor.
// The host drives the request fields, the core drives the result fields.
interface decrypt_3blocks_128_if;
  logic         start;
  logic [127:0] SK;
  logic [127:0] N;
  logic [63:0]  A;
  logic [63:0]  C;
  logic [127:0] T;
  logic         busy;
  logic         done;
  logic [63:0]  P;
  logic         tag_ok;

  modport master (
    output start, SK, N, A, C, T,
    input  busy, done, P, tag_ok
  );

  modport slave (
    input  start, SK, N, A, C, T,
    output busy, done, P, tag_ok
  );
endinterface

// File: rtl/decrypt_3blocks_128.sv
// Iterative Ascon-128 authenticated decryption of one AD block and one
// ciphertext block, one permutation round per clock. Phase boundary work
// is folded into the last round of each phase so a request takes exactly
// 42 round cycles after the load edge. Plaintext is only released at the
// result edge, and only when the recomputed tag matches.
module decrypt_3blocks_128 #(
  parameter logic [63:0] IV       = 64'h80400c0600000000,
  parameter int          ROUNDS_A = 12,
  parameter int          ROUNDS_B = 6
) (
  input logic                  CLK,
  input logic                  RST,
  decrypt_3blocks_128_if.slave bus
);

  // Single 10* padding block, byte 0x80 first in big-endian order.
  localparam logic [63:0] PAD = 64'h8000000000000000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD,
    ADPAD,
    MSG,
    FIN
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [63:0]  x0_q, x0_d;
  logic [63:0]  x1_q, x1_d;
  logic [63:0]  x2_q, x2_d;
  logic [63:0]  x3_q, x3_d;
  logic [63:0]  x4_q, x4_d;
  logic [127:0] key_q, key_d;
  logic [63:0]  a_q, a_d;
  logic [63:0]  c_q, c_d;
  logic [127:0] t_q, t_d;
  // Plaintext recovered during the MSG boundary; held back until the tag
  // has been checked.
  logic [63:0]  pint_q, pint_d;
  logic [63:0]  p_q, p_d;
  logic         tag_ok_q, tag_ok_d;
  logic         done_q, done_d;

  logic [3:0]   rounds_m1;
  logic [3:0]   rc_idx;
  logic         last_round;
  logic [63:0]  r0, r1, r2, r3, r4;
  logic [127:0] tc;
  logic         tag_match;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Constants run f0, e1, ... 4b; a short permutation uses the tail.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hf - idx, idx};
  endfunction

  // One Ascon round: constant addition, bit-sliced S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    a0 = s[319:256];
    a1 = s[255:192];
    a2 = s[191:128] ^ {56'h0, rc};
    a3 = s[127:64];
    a4 = s[63:0];
    a0 ^= a4;
    a4 ^= a3;
    a2 ^= a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 ^= t1;
    a1 ^= t2;
    a2 ^= t3;
    a3 ^= t4;
    a4 ^= t0;
    a1 ^= a0;
    a0 ^= a4;
    a3 ^= a2;
    a2 = ~a2;
    a0 ^= ror64(a0, 19) ^ ror64(a0, 28);
    a1 ^= ror64(a1, 61) ^ ror64(a1, 39);
    a2 ^= ror64(a2, 1)  ^ ror64(a2, 6);
    a3 ^= ror64(a3, 10) ^ ror64(a3, 17);
    a4 ^= ror64(a4, 7)  ^ ror64(a4, 41);
    return {a0, a1, a2, a3, a4};
  endfunction

  // Phase length and round-constant offset: INIT/FIN use the long permutation.
  always_comb begin
    rounds_m1 = 4'(ROUNDS_B - 1);
    if (state_q == INIT || state_q == FIN) begin
      rounds_m1 = 4'(ROUNDS_A - 1);
    end
    rc_idx     = cnt_q + (4'd11 - rounds_m1);
    last_round = (cnt_q == rounds_m1);
  end

  assign {r0, r1, r2, r3, r4} = ascon_round({x0_q, x1_q, x2_q, x3_q, x4_q},
                                            round_const(rc_idx));

  assign tc        = {r3 ^ key_q[127:64], r4 ^ key_q[63:0]};
  assign tag_match = (tc == t_q);

  // Next-state logic: load on accepted start, then one round per cycle with
  // the phase-boundary injections applied to the last round's output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    x3_d     = x3_q;
    x4_d     = x4_q;
    key_d    = key_q;
    a_d      = a_q;
    c_d      = c_q;
    t_d      = t_q;
    pint_d   = pint_q;
    p_d      = p_q;
    tag_ok_d = tag_ok_q;
    done_d   = 1'b0;

    if (state_q != IDLE) begin
      x0_d  = r0;
      x1_d  = r1;
      x2_d  = r2;
      x3_d  = r3;
      x4_d  = r4;
      cnt_d = last_round ? 4'd0 : cnt_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d    = IV;
          x1_d    = bus.SK[127:64];
          x2_d    = bus.SK[63:0];
          x3_d    = bus.N[127:64];
          x4_d    = bus.N[63:0];
          key_d   = bus.SK;
          a_d     = bus.A;
          c_d     = bus.C;
          t_d     = bus.T;
          cnt_d   = 4'd0;
          state_d = INIT;
        end
      end
      INIT: begin
        if (last_round) begin
          x3_d    = r3 ^ key_q[127:64];
          x4_d    = r4 ^ key_q[63:0];
          x0_d    = r0 ^ a_q;
          state_d = AD;
        end
      end
      AD: begin
        if (last_round) begin
          x0_d    = r0 ^ PAD;
          state_d = ADPAD;
        end
      end
      ADPAD: begin
        if (last_round) begin
          // Domain separation, then the ciphertext replaces the rate word.
          x4_d    = r4 ^ 64'd1;
          pint_d  = r0 ^ c_q;
          x0_d    = c_q;
          state_d = MSG;
        end
      end
      MSG: begin
        if (last_round) begin
          x0_d    = r0 ^ PAD;
          x1_d    = r1 ^ key_q[127:64];
          x2_d    = r2 ^ key_q[63:0];
          state_d = FIN;
        end
      end
      FIN: begin
        if (last_round) begin
          tag_ok_d = tag_match;
          p_d      = tag_match ? pint_q : 64'h0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset clears datapath as well so nothing leaks after an abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      x0_q     <= 64'h0;
      x1_q     <= 64'h0;
      x2_q     <= 64'h0;
      x3_q     <= 64'h0;
      x4_q     <= 64'h0;
      key_q    <= 128'h0;
      a_q      <= 64'h0;
      c_q      <= 64'h0;
      t_q      <= 128'h0;
      pint_q   <= 64'h0;
      p_q      <= 64'h0;
      tag_ok_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      x3_q     <= x3_d;
      x4_q     <= x4_d;
      key_q    <= key_d;
      a_q      <= a_d;
      c_q      <= c_d;
      t_q      <= t_d;
      pint_q   <= pint_d;
      p_q      <= p_d;
      tag_ok_q <= tag_ok_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.P      = p_q;
  assign bus.tag_ok = tag_ok_q;

endmodule

// File: tb/tb_decrypt_3blocks_128.sv
// Bench for decrypt_3blocks_128: a table-driven Ascon-128 encryptor model
// produces ciphertext/tag for known plaintexts; the stimulus pushes the
// expected result into a scoreboard and a monitor checks each done pulse.
module tb_decrypt_3blocks_128;

  localparam logic [63:0] IV  = 64'h80400c0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RCT [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  typedef struct {
    logic [63:0] p;
    logic        ok;
    longint      t_done;
  } exp_t;

  logic   CLK = 1'b0;
  logic   RST = 1'b1;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb[$];
  longint done_log[$];
  exp_t   mon_e;

  decrypt_3blocks_128_if bus();

  decrypt_3blocks_128 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference permutation: S-box by table lookup per bit column.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = 0; r < nr; r++) begin
      x[2][7:0] = x[2][7:0] ^ RCT[12-nr+r];
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[v];
        for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
      end
      x[0] = y[0] ^ {y[0][18:0], y[0][63:19]} ^ {y[0][27:0], y[0][63:28]};
      x[1] = y[1] ^ {y[1][60:0], y[1][63:61]} ^ {y[1][38:0], y[1][63:39]};
      x[2] = y[2] ^ {y[2][0],    y[2][63:1]}  ^ {y[2][5:0],  y[2][63:6]};
      x[3] = y[3] ^ {y[3][9:0],  y[3][63:10]} ^ {y[3][16:0], y[3][63:17]};
      x[4] = y[4] ^ {y[4][6:0],  y[4][63:7]}  ^ {y[4][40:0], y[4][63:41]};
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Ascon-128 encryption of one full AD block and one full plaintext block.
  function automatic void ascon_enc(input logic [127:0] k, input logic [127:0] n,
                                    input logic [63:0] ad, input logic [63:0] pt,
                                    output logic [63:0] ct, output logic [127:0] tag);
    logic [319:0] s;
    s = model_perm({IV, k, n}, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:256] = s[319:256] ^ ad;
    s = model_perm(s, 6);
    s[319:256] = s[319:256] ^ PAD;
    s = model_perm(s, 6);
    s[0] = s[0] ^ 1'b1;
    s[319:256] = s[319:256] ^ pt;
    ct = s[319:256];
    s = model_perm(s, 6);
    s[319:256] = s[319:256] ^ PAD;
    s[255:128] = s[255:128] ^ k;
    s = model_perm(s, 12);
    tag = s[127:0] ^ k;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (bus.done === 1'b1) begin
      done_log.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("result_P", bus.P, mon_e.p);
        check("result_tag_ok", bus.tag_ok, mon_e.ok);
        check("result_latency", 128'(cyc), 128'(mon_e.t_done));
        check("busy_low_at_done", bus.busy, 1'b0);
      end
    end
  end

  task automatic wait_done(input longint acc, input bit chk_busy, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      if (chk_busy && cyc == acc + 41) check("busy_before_result", bus.busy, 1'b1);
      @(negedge CLK);
      #1;
    end
    check("result_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic issue(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                       input logic [63:0] c, input logic [127:0] t,
                       input logic [63:0] ep, input logic eok);
    exp_t   e;
    longint acc;
    @(negedge CLK);
    bus.start = 1'b1;
    bus.SK = k;
    bus.N  = n;
    bus.A  = a;
    bus.C  = c;
    bus.T  = t;
    acc = cyc + 1;
    e.p = ep;
    e.ok = eok;
    e.t_done = acc + 42;
    sb.push_back(e);
    @(negedge CLK);
    bus.start = 1'b0;
    bus.SK = ~k;
    bus.N  = ~n;
    bus.A  = ~a;
    bus.C  = ~c;
    bus.T  = ~t;
    check("busy_after_accept", bus.busy, 1'b1);
    wait_done(acc, 1'b1, 60);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k0, n0, t0, k1, n1, t1, kh, nh, th;
    logic [63:0]  a0, p0, c0, a1, p1, c1, ah, ph, ch;
    longint       base;
    int           log0;
    longint       w[$];
    exp_t         e;

    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    n0 = k0;
    a0 = 64'h0001020304050607;
    p0 = 64'h0001020304050607;
    ascon_enc(k0, n0, a0, p0, c0, t0);

    // Reset held with start high: nothing may be accepted or reported.
    bus.start = 1'b1;
    bus.SK = k0;
    bus.N  = n0;
    bus.A  = a0;
    bus.C  = c0;
    bus.T  = t0;
    @(negedge CLK);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_P", bus.P, 64'h0);
    check("rst_tag_ok", bus.tag_ok, 1'b0);
    RST = 1'b0;
    bus.start = 1'b0;
    @(negedge CLK);
    check("idle_after_reset", bus.busy, 1'b0);

    // Round trip and the three forgery variants.
    issue(k0, n0, a0, c0, t0, p0, 1'b1);
    issue(k0, n0, a0, c0, t0 ^ 128'd1, 64'h0, 1'b0);
    issue(k0, n0, a0 ^ PAD, c0, t0, 64'h0, 1'b0);
    issue(k0, n0, a0, c0 ^ 64'd1, t0, 64'h0, 1'b0);

    // Further round trips with varied key/nonce/AD/plaintext.
    for (int i = 0; i < 4; i++) begin
      k1 = k0 ^ {32{4'(i + 1)}};
      n1 = ~n0 ^ {16{8'(i * 37)}};
      a1 = {8{8'(i + 3)}};
      p1 = 64'hdeadbeefcafef00d ^ {8{8'(i)}};
      ascon_enc(k1, n1, a1, p1, c1, t1);
      issue(k1, n1, a1, c1, t1, p1, 1'b1);
    end

    // Start held for 100 edges while SK is disturbed between acceptances.
    kh = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    nh = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    ah = 64'h1122334455667788;
    ph = 64'h99aabbccddeeff00;
    ascon_enc(kh, nh, ah, ph, ch, th);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.SK = kh;
    bus.N  = nh;
    bus.A  = ah;
    bus.C  = ch;
    bus.T  = th;
    base = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      e.p = ph;
      e.ok = 1'b1;
      e.t_done = base + 42 + 43 * j;
      sb.push_back(e);
    end
    log0 = done_log.size();
    for (int j = 0; j < 100; j++) begin
      @(negedge CLK);
      if (((cyc + 1 - base) % 43) >= 5 && ((cyc + 1 - base) % 43) <= 30) bus.SK = ~kh;
      else bus.SK = kh;
    end
    bus.start = 1'b0;
    wait_done(base, 1'b0, 200);
    for (int i = log0; i < done_log.size(); i++) begin
      if (done_log[i] <= base + 99) w.push_back(done_log[i]);
    end
    check("hs_done_count", w.size(), 2);
    check("hs_spacing", (w.size() >= 2) ? 128'(w[1] - w[0]) : 128'd0, 128'd43);

    // Reset 20 edges into a request: outputs cleared, no result reported.
    @(negedge CLK);
    bus.start = 1'b1;
    bus.SK = k0;
    bus.N  = n0;
    bus.A  = a0;
    bus.C  = c0;
    bus.T  = t0;
    @(negedge CLK);
    bus.start = 1'b0;
    check("abort_accepted", bus.busy, 1'b1);
    repeat (20) @(negedge CLK);
    log0 = done_log.size();
    RST = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_P", bus.P, 64'h0);
    check("abort_tag_ok", bus.tag_ok, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    check("abort_no_done", done_log.size() - log0, 0);
    issue(k0, n0, a0, c0, t0, p0, 1'b1);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decrypt_3blocks_128.md
# decrypt_3blocks_128

Iterative Ascon-128 authenticated decryption core: the receive-side counterpart of the 3-block encryptor. It processes one 128-bit key, one 128-bit nonce, one full 64-bit associated-data block and one full 64-bit ciphertext block, using one permutation round per clock. It returns the 64-bit plaintext and a tag-verification flag. A start/busy/done handshake lets a testbench or host sequencer drive it back-to-back from a vector file.

## Interface
Parameters:
- IV, 64'h80400c0600000000, Ascon-128 initial value (k=128, r=64, a=12, b=6)
- ROUNDS_A, 12, rounds in initialization and finalization
- ROUNDS_B, 6, rounds after each absorbed block

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only while busy=0
- SK  in  128  key; sampled with accepted start
- N  in  128  nonce; sampled with accepted start
- A  in  64  associated-data block; sampled with accepted start
- C  in  64  ciphertext block; sampled with accepted start
- T  in  128  received tag; sampled with accepted start
- busy  out  1  high from the edge that accepts start until the result edge
- done  out  1  one-cycle pulse; result valid
- P  out  64  plaintext; all zeros unless tag verified
- tag_ok  out  1  computed tag equals T

## Operation
- State is x0..x4, 64 bits each. Rounds follow standard Ascon:
  - Round constants: p^12 uses f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b. p^6 uses the last six of these.
  - Constant addition XORs the constant into x2 bits [7:0].
  - Substitution layer is the 5-bit Ascon S-box, bit-sliced.
  - Linear layer rotations (right): x0 19/28, x1 61/39, x2 1/6, x3 10/17, x4 7/41.
- Inputs are captured into internal registers at the accepting edge. External inputs may change freely afterwards.
- FSM states: IDLE, INIT, AD, ADPAD, MSG, FIN. A 4-bit round counter runs inside each state. Phase boundary work is applied combinationally to the output of the last round of each phase and registered at the same edge, so no extra cycles are added.
  - IDLE, start=1: load x0=IV, x1=SK[127:64], x2=SK[63:0], x3=N[127:64], x4=N[63:0]. Go to INIT.
  - INIT, 12 rounds. After round 12: x3^=SK[127:64], x4^=SK[63:0], then x0^=A. Go to AD.
  - AD, 6 rounds. After round 6: x0^=64'h8000000000000000 (AD padding block). Go to ADPAD.
  - ADPAD, 6 rounds. After round 6: x4^=1 (domain separation), then Pint=x0^C, x0=C. Go to MSG.
  - MSG, 6 rounds. After round 6: x0^=64'h8000000000000000 (empty final message block), x1^=SK[127:64], x2^=SK[63:0]. Go to FIN.
  - FIN, 12 rounds. After round 12: Tc={x3^SK[127:64], x4^SK[63:0]}. tag_ok<=(Tc==T). P<=tag_ok ? Pint : 0. Pulse done. Return to IDLE.
- Unverified plaintext is never exposed: P is written only at the result edge.
- start while busy=1 is ignored; it is not queued.

## Timing
- Reset values: busy=0, done=0, P=0, tag_ok=0, state IDLE, counter 0, x0..x4=0.
- Start accepted at edge k. The load happens at edge k. Rounds execute at edges k+1 through k+42 (12+6+6+6+12).
- Result edge is k+42: done=1 and busy=0 for the cycle after that edge. P and tag_ok hold until the next result edge or reset.
- busy=1 from edge k through edge k+41.
- Back-to-back: start high during the done cycle is accepted at the next edge, giving 43-cycle throughput.
- RST asserted at any point, including mid-permutation, clears everything immediately. No partial result and no done pulse are produced. The first start after RST deasserts behaves as a fresh request.

## Test plan
- Reset: RST high for 10 ns with start=1 -> busy=0, done=0, P=0, tag_ok=0 throughout. No acceptance until RST=0.
- Round-trip: SK=N=128'h000102030405060708090a0b0c0d0e0f, A=64'h0001020304050607, P=64'h0001020304050607 through encrypt_3blocks_128 top to get C,T. Feed C,T here -> done at exactly start+42 edges, P=64'h0001020304050607, tag_ok=1.
- Tag forgery: same vector with T[0] flipped -> tag_ok=0, P=64'h0. Repeat with A[63] flipped, then C[0] flipped -> same response.
- Handshake: start held high for 100 cycles -> exactly two done pulses, 43 cycles apart. Mid-run SK changes do not alter the result.
- Mid-operation reset: RST pulse 20 edges after acceptance -> outputs zero, no done pulse. A restart with the round-trip vector -> correct P, tag_ok=1.
- Regression: 200 vectors from sample/inputs_float128.txt, encrypted by the encryptor and decrypted here -> all P match, all tag_ok=1.
